assoc_mem_system: RTL and testbench
===================================

# assoc_mem_system

Parametrised write-back, write-allocate cache controller with integrated tag/data storage, replacing the direct-mapped memory system between the CPU memory stage and the banked main memory. Supports 1-way (direct-mapped) or 2-way set-associative organisation with per-set LRU replacement. Line fill and dirty write-back use a stall-aware memory handshake. CPU-side protocol is single-outstanding Rd/Wr with a one-cycle Done pulse.

## Interface
- WAYS, 2: associativity; legal values 1 or 2.
- INDEX_BITS, 5: set index width; sets = 2**INDEX_BITS; tag = 16 - INDEX_BITS - 3 bits.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- Addr  in  16  byte address; offset Addr[2:0], index Addr[INDEX_BITS+2:3], tag above.
- DataIn  in  16  write data.
- Rd, Wr  in  1  request strobes, sampled only in IDLE.
- DataOut  out  16  read data, valid while Done=1.
- Done  out  1  one-cycle completion pulse.
- Stall  out  1  high while a request is in flight and Done=0.
- CacheHit  out  1  qualifies Done; 1 = hit, no memory traffic.
- err  out  1  one-cycle pulse on illegal request.
- mem_addr  out  16  word-aligned memory address.
- mem_wdata  out  16  write-back data.
- mem_wr, mem_rd  out  1  memory request; at most one high.
- mem_stall  in  1  request not accepted this cycle; hold all mem_* outputs.
- mem_rdata  in  16  fill data, valid with mem_rvalid.
- mem_rvalid  in  1  one fill word returned, in request order.

## Operation
- Line: 4 words of 16 bits (8 bytes). Word select Addr[2:1].
- States: IDLE, COMPARE, WB, FILL_REQ, FILL_WAIT, DONE.
- IDLE: Rd&Wr or (Rd|Wr)&Addr[0] -> err pulse next cycle, stay IDLE, no state change. Rd^Wr legal -> latch Addr/DataIn/op, go COMPARE.
- COMPARE: tag match on a valid way = hit: read -> DataOut = word; write -> store word, set dirty. Done=1, CacheHit=1, LRU updated to point at the other way, -> IDLE.
- Miss victim: first invalid way (way 0 before way 1); else LRU way. WAYS=1: always way 0.
- Victim valid & dirty -> WB: 4 mem_wr, words 0..3 in order, mem_addr = {victim tag, index, word, 1'b0}. Word counter advances only on cycles with mem_stall=0. After word 3 accepted -> FILL_REQ.
- Otherwise -> FILL_REQ: 4 mem_rd, words 0..3, counter advances on mem_stall=0; after word 3 accepted -> FILL_WAIT (reads may overlap returns; returns counted by separate counter from FILL_REQ entry).
- FILL_WAIT: each mem_rvalid writes mem_rdata into victim word (return count). After 4th return: tag written, valid=1, dirty=0 -> DONE.
- DONE: perform latched access on the filled way as in a hit; Done=1, CacheHit=0, LRU updated -> IDLE.
- Rd/Wr/Addr changes while not IDLE are ignored.

## Timing
- Reset values: Done, CacheHit, err, Stall, mem_wr, mem_rd = 0; DataOut, mem_addr, mem_wdata = 0; all valid, dirty, LRU bits = 0; state IDLE; counters 0.
- Hit: request in IDLE cycle N -> Done/CacheHit in cycle N+1. Stall=0 in N+1 (Done cycle).
- Clean miss, no mem_stall, return latency L: Done at N+1+4+L+1 minimum; dirty miss adds 4.
- Stall=1 from cycle N+1 until the cycle before Done.
- mem_rvalid arriving before last read accepted is legal and counted.
- rst mid-operation: immediate abort, outstanding returns discarded, all lines invalid.
- err pulse cycle: Done=0, Stall=0.

## Structure
- Package assoc_mem_pkg: state enum, WORD_W=16, LINE_WORDS=4, OFFSET_BITS=3, tag-width function of INDEX_BITS.
- Sub-module cache_way: one way's tag/valid/dirty/data arrays with async read, sync write, async clear on rst; instantiated WAYS times via generate. LRU array and FSM stay in top.

## Test plan
- Cold read Addr=0x0012, return latency 2 -> 4 reads at 0x0010..0x0016, Done with CacheHit=0, DataOut=mem word 0x0012; repeat read -> Done at N+1, CacheHit=1.
- Write 0xBEEF to 0x0012 (hit), then reads mapping to same set with two other tags (WAYS=2) -> second miss evicts LRU line 0x0010 with 4 mem_wr, word 1 = 0xBEEF.
- WAYS=1, alternating tags on same index -> every access misses, clean victims produce no mem_wr.
- mem_stall held 3 cycles on word 2 of fill -> mem_addr/mem_rd held, exactly 4 reads accepted, correct data installed.
- Rd=Wr=1 and Rd with Addr=0x0013 -> err pulse, no memory traffic, cache unchanged.
- rst asserted in FILL_WAIT -> outputs zero same cycle; subsequent read of same address misses.

Source files
------------

// File: rtl/assoc_mem_pkg.sv
// Shared types and geometry for the associative cache controller.
package assoc_mem_pkg;

  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned WORD_W      = 16;
  localparam int unsigned LINE_WORDS  = 4;
  localparam int unsigned OFFSET_BITS = 3;
  localparam int unsigned WSEL_W      = 2;
  localparam int unsigned LINE_W      = WORD_W * LINE_WORDS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_WB,
    S_FILL_REQ,
    S_FILL_WAIT,
    S_DONE
  } state_t;

  function automatic int unsigned tag_width(input int unsigned index_bits);
    return ADDR_W - index_bits - OFFSET_BITS;
  endfunction

  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [WSEL_W-1:0] sel);
    return line[sel*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/cache_way.sv
// One cache way: per-set tag, valid, dirty and line data.
// Reads are asynchronous on idx; writes land on the rising edge.
module cache_way
  import assoc_mem_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 5,
  parameter int unsigned TAG_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] idx,
  input  logic                  word_we,
  input  logic [WSEL_W-1:0]     word_sel,
  input  logic [WORD_W-1:0]     word_data,
  input  logic                  set_dirty,
  input  logic                  install,
  input  logic [TAG_W-1:0]      install_tag,
  output logic                  line_valid,
  output logic                  line_dirty,
  output logic [TAG_W-1:0]      line_tag,
  output logic [LINE_W-1:0]     line_data
);

  localparam int unsigned SETS = 2 ** INDEX_BITS;

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [WORD_W-1:0] data_mem [SETS][LINE_WORDS];

  // Only the status bits need clearing; tag/data are don't-care while invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (install) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (set_dirty) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (install) tag_mem[idx] <= install_tag;
    if (word_we) data_mem[idx][word_sel] <= word_data;
  end

  assign line_valid = valid_q[idx];
  assign line_dirty = dirty_q[idx];
  assign line_tag   = tag_mem[idx];

  always_comb begin
    line_data = '0;
    for (int unsigned i = 0; i < LINE_WORDS; i++) begin
      line_data[i*WORD_W +: WORD_W] = data_mem[idx][i[WSEL_W-1:0]];
    end
  end

endmodule

// File: rtl/assoc_mem_system.sv
// Write-back, write-allocate cache controller (1- or 2-way, per-set LRU)
// between the CPU memory stage and a stall-aware banked main memory.
module assoc_mem_system
  import assoc_mem_pkg::*;
#(
  parameter int unsigned WAYS       = 2,
  parameter int unsigned INDEX_BITS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_wr,
  output logic        mem_rd,
  input  logic        mem_stall,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid
);

  localparam int unsigned TAG_W = tag_width(INDEX_BITS);
  localparam int unsigned SETS  = 2 ** INDEX_BITS;

  state_t                state_q, state_d;
  logic [ADDR_W-1:1]     req_addr_q;
  logic [WORD_W-1:0]     req_data_q;
  logic                  req_wr_q;
  logic                  victim_q;
  logic                  err_q;
  logic [WSEL_W-1:0]     wcnt_q;
  logic [2:0]            rcnt_q;
  logic [SETS-1:0]       lru_q;

  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [WSEL_W-1:0]     req_word;

  logic                  way_valid [2];
  logic                  way_dirty [2];
  logic [TAG_W-1:0]      way_tag   [2];
  logic [LINE_W-1:0]     way_line  [2];

  logic [1:0]            hit_w;
  logic                  hit, hit_way, miss_way, acc_way;
  logic                  req_ok, req_bad, fill_we, fill_last, cpu_wr, xfer_last;

  assign req_idx  = req_addr_q[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS];
  assign req_tag  = req_addr_q[ADDR_W-1:INDEX_BITS+OFFSET_BITS];
  assign req_word = req_addr_q[OFFSET_BITS-1:1];

  assign req_bad   = (Rd && Wr) || ((Rd || Wr) && Addr[0]);
  assign req_ok    = (Rd ^ Wr) && !Addr[0];
  assign xfer_last = !mem_stall && (wcnt_q == '1);
  // Returns are counted from FILL_REQ entry, so early returns overlap the reads.
  assign fill_we   = ((state_q == S_FILL_REQ) || (state_q == S_FILL_WAIT)) &&
                     mem_rvalid && !rcnt_q[2];
  assign fill_last = (state_q == S_FILL_WAIT) &&
                     (rcnt_q[2] || ((rcnt_q == 3'd3) && mem_rvalid));
  assign cpu_wr    = Done && req_wr_q;
  assign acc_way   = (state_q == S_DONE) ? victim_q : hit_way;
  assign err       = err_q;

  for (genvar w = 0; w < 2; w++) begin : g_way
    if (w < WAYS) begin : g_inst
      logic sel_fill, sel_cpu;
      assign sel_fill = fill_we && (victim_q == 1'(w));
      assign sel_cpu  = cpu_wr && (acc_way == 1'(w));

      cache_way #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W)
      ) u_way (
        .clk         (clk),
        .rst         (rst),
        .idx         (req_idx),
        .word_we     (sel_fill || sel_cpu),
        .word_sel    (sel_fill ? rcnt_q[WSEL_W-1:0] : req_word),
        .word_data   (sel_fill ? mem_rdata : req_data_q),
        .set_dirty   (sel_cpu),
        .install     (fill_last && (victim_q == 1'(w))),
        .install_tag (req_tag),
        .line_valid  (way_valid[w]),
        .line_dirty  (way_dirty[w]),
        .line_tag    (way_tag[w]),
        .line_data   (way_line[w])
      );
    end else begin : g_tie
      assign way_valid[w] = 1'b0;
      assign way_dirty[w] = 1'b0;
      assign way_tag[w]   = '0;
      assign way_line[w]  = '0;
    end
  end

  always_comb begin
    hit_w = '0;
    for (int unsigned w = 0; w < 2; w++) begin
      hit_w[w] = way_valid[w] && (way_tag[w] == req_tag);
    end
    hit     = |hit_w;
    hit_way = hit_w[1];
    if ((WAYS == 1) || !way_valid[0]) miss_way = 1'b0;
    else if (!way_valid[1])           miss_way = 1'b1;
    else                              miss_way = lru_q[req_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (req_ok) state_d = S_COMPARE;
      S_COMPARE: begin
        if (hit)                                          state_d = S_IDLE;
        else if (way_valid[miss_way] && way_dirty[miss_way]) state_d = S_WB;
        else                                              state_d = S_FILL_REQ;
      end
      S_WB:        if (xfer_last) state_d = S_FILL_REQ;
      S_FILL_REQ:  if (xfer_last) state_d = S_FILL_WAIT;
      S_FILL_WAIT: if (fill_last) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Done      = 1'b0;
    CacheHit  = 1'b0;
    DataOut   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wr    = 1'b0;
    mem_rd    = 1'b0;
    case (state_q)
      S_COMPARE: if (hit) begin
        Done     = 1'b1;
        CacheHit = 1'b1;
      end
      S_DONE: Done = 1'b1;
      S_WB: begin
        mem_wr    = 1'b1;
        mem_addr  = {way_tag[victim_q], req_idx, wcnt_q, 1'b0};
        mem_wdata = line_word(way_line[victim_q], wcnt_q);
      end
      S_FILL_REQ: begin
        mem_rd   = 1'b1;
        mem_addr = {req_tag, req_idx, wcnt_q, 1'b0};
      end
      default: ;
    endcase
    if (Done) DataOut = line_word(way_line[acc_way], req_word);
    Stall = (state_q != S_IDLE) && !Done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_addr_q <= '0;
      req_data_q <= '0;
      req_wr_q   <= 1'b0;
      victim_q   <= 1'b0;
      err_q      <= 1'b0;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      lru_q      <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_bad) begin
            err_q <= 1'b1;
          end else if (req_ok) begin
            req_addr_q <= Addr[ADDR_W-1:1];
            req_data_q <= DataIn;
            req_wr_q   <= Wr;
          end
        end
        S_COMPARE: begin
          if (hit) begin
            lru_q[req_idx] <= ~hit_way;
          end else begin
            victim_q <= miss_way;
            wcnt_q   <= '0;
            rcnt_q   <= '0;
          end
        end
        S_WB: if (!mem_stall) wcnt_q <= wcnt_q + 1'b1;
        S_FILL_REQ: begin
          if (!mem_stall) wcnt_q <= wcnt_q + 1'b1;
          if (fill_we)    rcnt_q <= rcnt_q + 3'd1;
        end
        S_FILL_WAIT: if (fill_we) rcnt_q <= rcnt_q + 3'd1;
        S_DONE:      lru_q[req_idx] <= ~victim_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_assoc_mem_system.sv
// Directed bench for assoc_mem_system: a 2-way and a 1-way instance share one
// latency-2 main-memory model with optional per-address stall injection.
module tb_assoc_mem_system;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] Addr = '0, DataIn = '0;
  logic rd_drv = 1'b0, wr_drv = 1'b0, use1 = 1'b0;
  logic mem_stall = 1'b0, mem_rvalid = 1'b0;
  logic [15:0] mem_rdata = '0;

  logic Rd_a, Wr_a, Rd_b, Wr_b;
  logic [15:0] DataOut_a, mem_addr_a, mem_wdata_a, DataOut_b, mem_addr_b, mem_wdata_b;
  logic Done_a, Stall_a, CacheHit_a, err_a, mem_wr_a, mem_rd_a;
  logic Done_b, Stall_b, CacheHit_b, err_b, mem_wr_b, mem_rd_b;

  assign Rd_a = rd_drv & ~use1;
  assign Wr_a = wr_drv & ~use1;
  assign Rd_b = rd_drv & use1;
  assign Wr_b = wr_drv & use1;

  always #5 clk = ~clk;

  assoc_mem_system #(.WAYS(2), .INDEX_BITS(5)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd_a), .Wr(Wr_a),
    .DataOut(DataOut_a), .Done(Done_a), .Stall(Stall_a), .CacheHit(CacheHit_a), .err(err_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_wr(mem_wr_a), .mem_rd(mem_rd_a),
    .mem_stall(mem_stall), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  assoc_mem_system #(.WAYS(1), .INDEX_BITS(5)) dut1 (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd_b), .Wr(Wr_b),
    .DataOut(DataOut_b), .Done(Done_b), .Stall(Stall_b), .CacheHit(CacheHit_b), .err(err_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_wr(mem_wr_b), .mem_rd(mem_rd_b),
    .mem_stall(mem_stall), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  logic done_s, hit_s, stall_s, err_s, m_rd_s, m_wr_s;
  logic [15:0] dout_s, m_addr_s, m_wdata_s;
  assign done_s    = use1 ? Done_b     : Done_a;
  assign hit_s     = use1 ? CacheHit_b : CacheHit_a;
  assign stall_s   = use1 ? Stall_b    : Stall_a;
  assign err_s     = use1 ? err_b      : err_a;
  assign dout_s    = use1 ? DataOut_b  : DataOut_a;
  assign m_rd_s    = use1 ? mem_rd_b   : mem_rd_a;
  assign m_wr_s    = use1 ? mem_wr_b   : mem_wr_a;
  assign m_addr_s  = use1 ? mem_addr_b : mem_addr_a;
  assign m_wdata_s = use1 ? mem_wdata_b : mem_wdata_a;

  int cyc = 0, rd_cnt = 0, wr_cnt = 0, stall_hold = 0, stall_left = 0;
  logic [15:0] stall_addr = '0;
  logic [15:0] ret_data_q[$];
  int          ret_cyc_q[$];
  logic [15:0] rd_log[$];
  logic [15:0] wr_addr_log[$];
  logic [15:0] wr_data_log[$];
  logic [15:0] mem_q[int];

  int vectors = 0, miscompares = 0;

  function automatic logic [15:0] mem_init(input logic [15:0] a);
    return {a[7:0] ^ a[15:8], ~a[7:0]};
  endfunction

  function automatic logic [15:0] mem_read(input logic [15:0] a);
    if (mem_q.exists(int'(a))) return mem_q[int'(a)];
    return mem_init(a);
  endfunction

  // Memory model: decisions made mid-cycle, seen by the DUT at the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        ret_data_q.delete();
        ret_cyc_q.delete();
        mem_stall  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (ret_cyc_q.size() > 0 && ret_cyc_q[0] == cyc) begin
          mem_rvalid = 1'b1;
          mem_rdata  = ret_data_q.pop_front();
          void'(ret_cyc_q.pop_front());
        end
        mem_stall = 1'b0;
        if (stall_left > 0 && m_rd_s && m_addr_s == stall_addr) begin
          mem_stall = 1'b1;
          stall_left--;
          stall_hold++;
        end
        if (m_rd_s && !mem_stall) begin
          rd_cnt++;
          rd_log.push_back(m_addr_s);
          ret_data_q.push_back(mem_read(m_addr_s));
          ret_cyc_q.push_back(cyc + LAT);
        end
        if (m_wr_s && !mem_stall) begin
          wr_cnt++;
          wr_addr_log.push_back(m_addr_s);
          wr_data_log.push_back(m_wdata_s);
          mem_q[int'(m_addr_s)] = m_wdata_s;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                        output int lat, output logic hit, output logic [15:0] dout,
                        output logic stall_ok);
    @(negedge clk);
    Addr = a; DataIn = d; rd_drv = rd; wr_drv = wr;
    lat = -1; hit = 1'b0; dout = '0; stall_ok = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      rd_drv = 1'b0; wr_drv = 1'b0;
      if (done_s) begin
        lat = i; hit = hit_s; dout = dout_s;
        if (stall_s) stall_ok = 1'b0;
        break;
      end
      if (!stall_s) stall_ok = 1'b0;
    end
  endtask

  task automatic req_check(input string tag, input logic rd, input logic wr,
                           input logic [15:0] a, input logic [15:0] d,
                           input int exp_lat, input logic exp_hit,
                           input logic chk_data, input logic [15:0] exp_data,
                           input int exp_rd, input int exp_wr);
    int lat, r0, w0;
    logic hit, stall_ok;
    logic [15:0] dout;
    r0 = rd_cnt; w0 = wr_cnt;
    do_req(rd, wr, a, d, lat, hit, dout, stall_ok);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_hit"}, hit, exp_hit);
    chk({tag, "_stall"}, stall_ok, 1'b1);
    if (chk_data) chk({tag, "_data"}, dout, exp_data);
    chk({tag, "_reads"}, rd_cnt - r0, exp_rd);
    chk({tag, "_writes"}, wr_cnt - w0, exp_wr);
  endtask

  task automatic err_check(input string tag, input logic rd, input logic wr, input logic [15:0] a);
    int r0, w0;
    r0 = rd_cnt; w0 = wr_cnt;
    @(negedge clk);
    Addr = a; rd_drv = rd; wr_drv = wr;
    @(negedge clk);
    rd_drv = 1'b0; wr_drv = 1'b0;
    chk({tag, "_err"}, err_s, 1'b1);
    chk({tag, "_done_stall"}, {done_s, stall_s}, 2'b00);
    @(negedge clk);
    chk({tag, "_err_clear"}, err_s, 1'b0);
    chk({tag, "_idle"}, {done_s, stall_s}, 2'b00);
    chk({tag, "_traffic"}, (rd_cnt - r0) + (wr_cnt - w0), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ctl_a", {Done_a, CacheHit_a, err_a, Stall_a, mem_wr_a, mem_rd_a}, '0);
    chk("rst_bus_a", {DataOut_a, mem_addr_a}, '0);
    chk("rst_wdata_a", mem_wdata_a, '0);
    chk("rst_ctl_b", {Done_b, CacheHit_b, err_b, Stall_b, mem_wr_b, mem_rd_b}, '0);
    chk("rst_bus_b", {DataOut_b, mem_addr_b}, '0);
    rst = 1'b0;
    @(negedge clk);

    // Cold miss, fill order, then hit.
    rd_log.delete();
    req_check("cold_rd", 1, 0, 16'h0012, 16'h0, 8, 0, 1, mem_init(16'h0012), 4, 0);
    chk("cold_rd_addr0", rd_log[0], 16'h0010);
    chk("cold_rd_addr1", rd_log[1], 16'h0012);
    chk("cold_rd_addr3", rd_log[3], 16'h0016);
    req_check("hit_rd", 1, 0, 16'h0012, 16'h0, 1, 1, 1, mem_init(16'h0012), 0, 0);
    req_check("hit_wr", 0, 1, 16'h0012, 16'hBEEF, 1, 1, 0, 16'h0, 0, 0);
    req_check("hit_rd_new", 1, 0, 16'h0012, 16'h0, 1, 1, 1, 16'hBEEF, 0, 0);

    // Fill the other way, then evict the dirty LRU line.
    req_check("way1_fill", 1, 0, 16'h0112, 16'h0, 8, 0, 1, mem_init(16'h0112), 4, 0);
    wr_addr_log.delete(); wr_data_log.delete();
    req_check("dirty_evict", 1, 0, 16'h0212, 16'h0, 12, 0, 1, mem_init(16'h0212), 4, 4);
    chk("wb_count", wr_addr_log.size(), 4);
    chk("wb_addr0", wr_addr_log[0], 16'h0010);
    chk("wb_addr1", wr_addr_log[1], 16'h0012);
    chk("wb_data0", wr_data_log[0], mem_init(16'h0010));
    chk("wb_data1", wr_data_log[1], 16'hBEEF);
    chk("wb_addr3", wr_addr_log[3], 16'h0016);
    req_check("survivor_hit", 1, 0, 16'h0112, 16'h0, 1, 1, 1, mem_init(16'h0112), 0, 0);
    req_check("refetch_wb", 1, 0, 16'h0012, 16'h0, 8, 0, 1, 16'hBEEF, 4, 0);

    // Illegal requests leave cache and memory untouched.
    err_check("err_rdwr", 1, 1, 16'h0012);
    err_check("err_odd", 1, 0, 16'h0013);
    req_check("post_err_hit", 1, 0, 16'h0012, 16'h0, 1, 1, 1, 16'hBEEF, 0, 0);

    // Stall held three cycles on fill word 2.
    stall_addr = 16'h0034; stall_left = 3; stall_hold = 0;
    rd_log.delete();
    req_check("stall_fill", 1, 0, 16'h0030, 16'h0, 11, 0, 1, mem_init(16'h0030), 4, 0);
    chk("stall_hold", stall_hold, 3);
    chk("stall_rd2", rd_log[2], 16'h0034);
    chk("stall_rd3", rd_log[3], 16'h0036);
    req_check("stall_w2_hit", 1, 0, 16'h0034, 16'h0, 1, 1, 1, mem_init(16'h0034), 0, 0);
    req_check("stall_w3_hit", 1, 0, 16'h0036, 16'h0, 1, 1, 1, mem_init(16'h0036), 0, 0);

    // Reset while waiting on fill returns.
    @(negedge clk);
    Addr = 16'h0040; rd_drv = 1'b1;
    @(negedge clk);
    rd_drv = 1'b0;
    repeat (5) @(negedge clk);
    chk("fw_stall", Stall_a, 1'b1);
    chk("fw_no_rd", mem_rd_a, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_mid_ctl", {Done_a, Stall_a, mem_rd_a, mem_wr_a, CacheHit_a, err_a}, '0);
    chk("rst_mid_bus", {DataOut_a, mem_addr_a}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    req_check("post_rst_rd", 1, 0, 16'h0040, 16'h0, 8, 0, 1, mem_init(16'h0040), 4, 0);
    req_check("post_rst_old", 1, 0, 16'h0112, 16'h0, 8, 0, 1, mem_init(16'h0112), 4, 0);

    // Direct-mapped instance: alternating tags on one index always miss.
    use1 = 1'b1;
    req_check("dm_rd_a", 1, 0, 16'h0050, 16'h0, 8, 0, 1, mem_init(16'h0050), 4, 0);
    req_check("dm_rd_b", 1, 0, 16'h0150, 16'h0, 8, 0, 1, mem_init(16'h0150), 4, 0);
    req_check("dm_rd_a2", 1, 0, 16'h0050, 16'h0, 8, 0, 1, mem_init(16'h0050), 4, 0);
    req_check("dm_wr_b", 0, 1, 16'h0152, 16'h1234, 8, 0, 0, 16'h0, 4, 0);
    wr_addr_log.delete(); wr_data_log.delete();
    req_check("dm_dirty", 1, 0, 16'h0050, 16'h0, 12, 0, 1, mem_init(16'h0050), 4, 4);
    chk("dm_wb_addr1", wr_addr_log[1], 16'h0152);
    chk("dm_wb_data1", wr_data_log[1], 16'h1234);
    req_check("dm_refetch", 1, 0, 16'h0152, 16'h0, 8, 0, 1, 16'h1234, 4, 0);
    use1 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
